// File: rtl/issue_scoreboard.sv
// Latency-aware register scoreboard and issue controller that sits beside decode.
// Optional macro SCOREBOARD_FORWARDING_EN: results are consumable from the bypass network (no writeback wait).
module issue_scoreboard #(
   parameter int LAT_ALU  = 1,
   parameter int LAT_LOAD = 2,
   parameter int LAT_MUL  = 3,
   parameter int LAT_DIV  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issueValid,
   input  logic [4:0]  rs1Addr,
   input  logic        rs1Use,
   input  logic [4:0]  rs2Addr,
   input  logic        rs2Use,
   input  logic [4:0]  rdAddr,
   input  logic        rdWEnable,
   input  logic [1:0]  unitClass,
   input  logic        flush,
   input  logic        memStall,
   output logic        isDataHazard,
   output logic        isStructHazard,
   output logic        stall,
   output logic        issueAccept,
   output logic        divBusy,
   output logic [31:0] pendingMask
);

`ifdef SCOREBOARD_FORWARDING_EN
   localparam int WB_EXTRA = 0;
`else
   localparam int WB_EXTRA = 2;
`endif

   typedef enum logic [1:0] {
      UC_ALU  = 2'd0,
      UC_LOAD = 2'd1,
      UC_MUL  = 2'd2,
      UC_DIV  = 2'd3
   } unitClassT;

   localparam logic [4:0] DIV_BUSY = 5'(LAT_DIV - 1);

   if (LAT_DIV < 2 || LAT_DIV + WB_EXTRA > 31) begin : gBadDivLat
      $error("issue_scoreboard: need 2 <= LAT_DIV and LAT_DIV + WB_EXTRA <= 31");
   end
   if (LAT_ALU < 1 || LAT_LOAD < 1 || LAT_MUL < 1 ||
       LAT_ALU + WB_EXTRA > 31 || LAT_LOAD + WB_EXTRA > 31 || LAT_MUL + WB_EXTRA > 31) begin : gBadUnitLat
      $error("issue_scoreboard: unit latencies must be in 1..31 including writeback delay");
   end

   function automatic logic [4:0] effLat(input logic [1:0] uc);
      case (unitClassT'(uc))
         UC_ALU:  effLat = 5'(LAT_ALU + WB_EXTRA);
         UC_LOAD: effLat = 5'(LAT_LOAD + WB_EXTRA);
         UC_MUL:  effLat = 5'(LAT_MUL + WB_EXTRA);
         default: effLat = 5'(LAT_DIV + WB_EXTRA);
      endcase
   endfunction

   logic [4:0] cnt [32];
   logic [4:0] divCnt;
   logic [4:0] issueLat;
   logic       isDiv;
   logic       rawHaz;
   logic       wawHaz;
   logic       wrTrack;

   always_comb begin
      issueLat = effLat(unitClass);
      isDiv    = (unitClass == UC_DIV);
      rawHaz   = (rs1Use && rs1Addr != 5'd0 && cnt[rs1Addr] != 5'd0) ||
                 (rs2Use && rs2Addr != 5'd0 && cnt[rs2Addr] != 5'd0);
      // A younger write must not land before an older, slower one to the same rd.
      wawHaz   = rdWEnable && rdAddr != 5'd0 && cnt[rdAddr] > issueLat;
   end

   always_comb begin
      isDataHazard   = issueValid && (rawHaz || wawHaz);
      isStructHazard = issueValid && isDiv && divCnt != 5'd0;
      stall          = isDataHazard || isStructHazard || memStall;
      issueAccept    = issueValid && !stall && !flush;
      wrTrack        = issueAccept && rdWEnable && rdAddr != 5'd0;
      divBusy        = (divCnt != 5'd0);
   end

   always_comb begin
      pendingMask = '0;
      for (int i = 1; i < 32; i++) begin
         pendingMask[i] = (cnt[i] != 5'd0);
      end
   end

   // Counts exclude the issue cycle itself, so a value of L-1 is loaded:
   // a 1-cycle producer is already consumable by the next decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            cnt[i] <= '0;
         end
         divCnt <= '0;
      end else if (!memStall) begin
         for (int i = 1; i < 32; i++) begin
            if (wrTrack && rdAddr == 5'(i)) begin
               cnt[i] <= issueLat - 5'd1;
            end else if (cnt[i] != 5'd0) begin
               cnt[i] <= cnt[i] - 5'd1;
            end
         end
         if (issueAccept && isDiv) begin
            divCnt <= DIV_BUSY;
         end else if (divCnt != 5'd0) begin
            divCnt <= divCnt - 5'd1;
         end
      end
   end

`ifndef SYNTHESIS
   aNoAcceptOnStall: assert property (@(posedge clk) disable iff (!rst) !(issueAccept && stall));
   aDivBound:        assert property (@(posedge clk) disable iff (!rst) divCnt <= DIV_BUSY);
   aX0Untracked:     assert property (@(posedge clk) disable iff (!rst) !pendingMask[0]);
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard (stall counts, masks, reset, freeze).
module tb_issue_scoreboard;

`ifdef SCOREBOARD_FORWARDING_EN
   localparam int WB = 0;
`else
   localparam int WB = 2;
`endif
   localparam int LAT_DIV = 16;
   localparam int LA = 1 + WB;
   localparam int LL = 2 + WB;
   localparam int LM = 3 + WB;
   localparam int LD = LAT_DIV + WB;

   localparam logic [1:0] U_ALU  = 2'd0;
   localparam logic [1:0] U_LOAD = 2'd1;
   localparam logic [1:0] U_MUL  = 2'd2;
   localparam logic [1:0] U_DIV  = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        issueValid;
   logic [4:0]  rs1Addr;
   logic        rs1Use;
   logic [4:0]  rs2Addr;
   logic        rs2Use;
   logic [4:0]  rdAddr;
   logic        rdWEnable;
   logic [1:0]  unitClass;
   logic        flush;
   logic        memStall;
   logic        isDataHazard;
   logic        isStructHazard;
   logic        stall;
   logic        issueAccept;
   logic        divBusy;
   logic [31:0] pendingMask;

   int nTests = 0;
   int nFail  = 0;

   issue_scoreboard #(
      .LAT_ALU(1), .LAT_LOAD(2), .LAT_MUL(3), .LAT_DIV(LAT_DIV)
   ) dut (
      .clk(clk), .rst(rst), .issueValid(issueValid),
      .rs1Addr(rs1Addr), .rs1Use(rs1Use), .rs2Addr(rs2Addr), .rs2Use(rs2Use),
      .rdAddr(rdAddr), .rdWEnable(rdWEnable), .unitClass(unitClass),
      .flush(flush), .memStall(memStall),
      .isDataHazard(isDataHazard), .isStructHazard(isStructHazard), .stall(stall),
      .issueAccept(issueAccept), .divBusy(divBusy), .pendingMask(pendingMask)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setIdle();
      issueValid = 1'b0;
      rs1Addr = '0; rs1Use = 1'b0;
      rs2Addr = '0; rs2Use = 1'b0;
      rdAddr = '0; rdWEnable = 1'b0;
      unitClass = U_ALU;
      flush = 1'b0;
      memStall = 1'b0;
   endtask

   task automatic issue(input logic [1:0] uc, input logic [4:0] rd, input logic we,
                        input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
      issueValid = 1'b1;
      unitClass = uc;
      rdAddr = rd; rdWEnable = we;
      rs1Addr = r1; rs1Use = u1;
      rs2Addr = r2; rs2Use = u2;
      flush = 1'b0;
      memStall = 1'b0;
   endtask

   task automatic drain();
      setIdle();
      repeat (LD + 4) tick();
   endtask

   // Holds the current decode instruction until accepted, counting stall cycles.
   task automatic waitAccept(output int nStall, output int nData, output int nStruct, output bit ok);
      nStall = 0; nData = 0; nStruct = 0; ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         #1;
         if (issueAccept) begin
            ok = 1'b1;
            break;
         end
         nStall++;
         if (isDataHazard) nData++;
         if (isStructHazard) nStruct++;
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      setIdle();
   endtask

   task automatic test_reset();
      logic ms;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         issueValid = 1'b1;
         rs1Addr = 5'($urandom); rs1Use = 1'($urandom);
         rs2Addr = 5'($urandom); rs2Use = 1'($urandom);
         rdAddr = 5'($urandom); rdWEnable = 1'($urandom);
         unitClass = 2'($urandom); flush = 1'($urandom);
         ms = 1'($urandom);
         memStall = ms;
         #1;
         nTests++;
         if (pendingMask !== 32'h0) begin nFail++; $display("FAIL reset_pending: got %h want 0", pendingMask); end
         nTests++;
         if (divBusy !== 1'b0) begin nFail++; $display("FAIL reset_divBusy: got %b want 0", divBusy); end
         nTests++;
         if (stall !== ms) begin nFail++; $display("FAIL reset_stall: got %b want %b", stall, ms); end
         nTests++;
         if (isDataHazard !== 1'b0 || isStructHazard !== 1'b0) begin
            nFail++; $display("FAIL reset_hazard: got data=%b struct=%b want 0/0", isDataHazard, isStructHazard);
         end
         tick();
      end
      setIdle();
      rst = 1'b1;
      tick();
      issue(U_ALU, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      nTests++;
      if (issueAccept !== 1'b1) begin nFail++; $display("FAIL first_alu_accept: got %b want 1", issueAccept); end
      tick();
      setIdle();
      #1;
      nTests++;
      if (pendingMask !== ((LA > 1) ? 32'h20 : 32'h0)) begin
         nFail++; $display("FAIL first_alu_mask: got %h want %h", pendingMask, (LA > 1) ? 32'h20 : 32'h0);
      end
      drain();
   endtask

   task automatic test_load_use(input bit viaRs2);
      int nS, nD, nSt;
      bit ok;
      issue(U_LOAD, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      nTests++;
      if (issueAccept !== 1'b1) begin nFail++; $display("FAIL load_accept: got %b want 1", issueAccept); end
      tick();
      if (viaRs2) issue(U_ALU, 5'd10, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1);
      else        issue(U_ALU, 5'd10, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
      waitAccept(nS, nD, nSt, ok);
      nTests++;
      if (!ok) begin nFail++; $display("FAIL load_use_timeout: got no accept want accept (rs2=%0d)", viaRs2); end
      nTests++;
      if (nD != LL - 1) begin nFail++; $display("FAIL load_use_stalls: got %0d want %0d (rs2=%0d)", nD, LL - 1, viaRs2); end
      #1;
      nTests++;
      if (pendingMask !== ((LA > 1) ? 32'h400 : 32'h0)) begin
         nFail++; $display("FAIL load_use_mask: got %h want %h", pendingMask, (LA > 1) ? 32'h400 : 32'h0);
      end
      drain();
   endtask

   task automatic test_same_src();
      int nS, nD, nSt;
      bit ok;
      issue(U_LOAD, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      issue(U_ALU, 5'd11, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1);
      waitAccept(nS, nD, nSt, ok);
      nTests++;
      if (!ok || nS != LL - 1) begin nFail++; $display("FAIL same_src_stalls: got %0d ok=%0d want %0d", nS, ok, LL - 1); end
      drain();
   endtask

   task automatic test_divider();
      int nS, nD, nSt;
      bit ok;
      issue(U_DIV, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      nTests++;
      if (issueAccept !== 1'b1) begin nFail++; $display("FAIL div_accept: got %b want 1", issueAccept); end
      tick();
      issue(U_DIV, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      waitAccept(nS, nD, nSt, ok);
      nTests++;
      if (!ok || nSt != LAT_DIV - 1) begin nFail++; $display("FAIL div_struct_stalls: got %0d ok=%0d want %0d", nSt, ok, LAT_DIV - 1); end
      nTests++;
      if (nD != 0) begin nFail++; $display("FAIL div_no_data_hazard: got %0d want 0", nD); end
      drain();
      issue(U_DIV, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      issue(U_ALU, 5'd12, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
      waitAccept(nS, nD, nSt, ok);
      nTests++;
      if (!ok || nD != LD - 1) begin nFail++; $display("FAIL div_consumer_stalls: got %0d ok=%0d want %0d", nD, ok, LD - 1); end
      drain();
   endtask

   task automatic test_waw();
      int nS, nD, nSt;
      bit ok;
      issue(U_MUL, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      issue(U_ALU, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      waitAccept(nS, nD, nSt, ok);
      nTests++;
      if (!ok || nD != LM - 1 - LA) begin nFail++; $display("FAIL waw_stalls: got %0d ok=%0d want %0d", nD, ok, LM - 1 - LA); end
      #1;
      nTests++;
      if (pendingMask !== ((LA > 1) ? 32'h200 : 32'h0)) begin
         nFail++; $display("FAIL waw_mask: got %h want %h", pendingMask, (LA > 1) ? 32'h200 : 32'h0);
      end
      drain();
   endtask

   task automatic test_x0_flush();
      issue(U_LOAD, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      nTests++;
      if (issueAccept !== 1'b1) begin nFail++; $display("FAIL x0_accept: got %b want 1", issueAccept); end
      tick();
      setIdle();
      #1;
      nTests++;
      if (pendingMask !== 32'h0) begin nFail++; $display("FAIL x0_mask: got %h want 0", pendingMask); end
      tick();
      issue(U_ALU, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      flush = 1'b1;
      #1;
      nTests++;
      if (issueAccept !== 1'b0 || stall !== 1'b0) begin
         nFail++; $display("FAIL flush_accept: got accept=%b stall=%b want 0/0", issueAccept, stall);
      end
      tick();
      setIdle();
      #1;
      nTests++;
      if (pendingMask[4] !== 1'b0) begin nFail++; $display("FAIL flush_mask: got %h want bit4 clear", pendingMask); end
      tick();
      issue(U_LOAD, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      issue(U_ALU, 5'd13, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
      flush = 1'b1;
      #1;
      nTests++;
      if (isDataHazard !== 1'b1 || issueAccept !== 1'b0) begin
         nFail++; $display("FAIL flush_hazard_visible: got haz=%b accept=%b want 1/0", isDataHazard, issueAccept);
      end
      tick();
      drain();
   endtask

   task automatic test_memstall();
      int busy;
      logic [31:0] pmSnap;
      busy = 0;
      pmSnap = '0;
      issue(U_DIV, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      setIdle();
      for (int k = 0; k < 60; k++) begin
         memStall = (k >= 2 && k < 7);
         issueValid = memStall;
         unitClass = U_ALU; rdAddr = 5'd12; rdWEnable = memStall;
         #1;
         if (!divBusy && k >= 7) break;
         if (divBusy) busy++;
         if (k == 2) begin
            pmSnap = pendingMask;
            nTests++;
            if (stall !== 1'b1 || issueAccept !== 1'b0) begin
               nFail++; $display("FAIL memstall_block: got stall=%b accept=%b want 1/0", stall, issueAccept);
            end
         end
         if (k == 7) begin
            nTests++;
            if (pendingMask !== pmSnap || pendingMask !== 32'h80) begin
               nFail++; $display("FAIL memstall_freeze: got %h want %h", pendingMask, 32'h80);
            end
         end
         @(posedge clk);
         #1;
      end
      setIdle();
      nTests++;
      if (busy != LAT_DIV - 1 + 5) begin nFail++; $display("FAIL memstall_divbusy: got %0d want %0d", busy, LAT_DIV - 1 + 5); end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      for (int r = 1; r <= 3; r++) begin
         issue(U_ALU, 5'(r), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
         #1;
         nTests++;
         if (issueAccept !== 1'b1) begin nFail++; $display("FAIL b2b_accept_x%0d: got %b want 1", r, issueAccept); end
         tick();
      end
      setIdle();
      #1;
      exp = '0;
      if (LA - 1 >= 1) exp[3] = 1'b1;
      if (LA - 1 >= 2) exp[2] = 1'b1;
      if (LA - 1 >= 3) exp[1] = 1'b1;
      nTests++;
      if (pendingMask !== exp) begin nFail++; $display("FAIL b2b_mask: got %h want %h", pendingMask, exp); end
      drain();
   endtask

   task automatic test_reset_midop();
      issue(U_DIV, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      setIdle();
      tick();
      nTests++;
      if (divBusy !== 1'b1 || pendingMask !== 32'h80) begin
         nFail++; $display("FAIL midop_pre: got busy=%b mask=%h want 1/%h", divBusy, pendingMask, 32'h80);
      end
      #1;
      rst = 1'b0;
      #1;
      nTests++;
      if (divBusy !== 1'b0 || pendingMask !== 32'h0) begin
         nFail++; $display("FAIL midop_reset: got busy=%b mask=%h want 0/0", divBusy, pendingMask);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
   endtask

   initial begin
      setIdle();
      rst = 1'b0;
      test_reset();
      test_load_use(1'b0);
      test_load_use(1'b1);
      test_same_src();
      test_divider();
      test_waw();
      test_x0_flush();
      test_memstall();
      test_back_to_back();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
